// File: rtl/duc_quad.sv
// Quad-lane digital up-converter: one complex baseband sample per clock in,
// four real DAC samples per clock out, mixed by four unrolled rotation CORDICs.
module duc_lane #(
    parameter int STAGES = 16,
    parameter int LANE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [19:0]        acc,
    input  logic [19:0]        pinc,
    input  logic [19:0]        poff,
    input  logic signed [13:0] i_in,
    input  logic signed [13:0] q_in,
    input  logic               vld,
    output logic signed [15:0] dout
);
    localparam logic [19:0] KMUL = 20'(LANE);

    function automatic logic signed [19:0] atan_lut(input int i);
        case (i)
            0:  return 20'sd131072;
            1:  return 20'sd77376;
            2:  return 20'sd40884;
            3:  return 20'sd20753;
            4:  return 20'sd10417;
            5:  return 20'sd5213;
            6:  return 20'sd2607;
            7:  return 20'sd1304;
            8:  return 20'sd652;
            9:  return 20'sd326;
            10: return 20'sd163;
            11: return 20'sd81;
            12: return 20'sd41;
            13: return 20'sd20;
            14: return 20'sd10;
            15: return 20'sd5;
            default: return 20'sd0;
        endcase
    endfunction

    logic [19:0]        ph;
    logic signed [13:0] i2, q2;
    logic signed [17:0] xs [STAGES+1];
    logic signed [17:0] ys [STAGES+1];
    logic signed [19:0] zs [STAGES+1];
    logic signed [17:0] xe, ye;
    logic signed [18:0] rnd, sh;
    logic signed [15:0] sat;
    logic               unused_tail;

    // Samples carry 2 guard LSBs through the CORDIC; the output rounding removes them.
    assign xe = {{2{i2[13]}}, i2, 2'b00};
    assign ye = {{2{q2[13]}}, q2, 2'b00};
    assign unused_tail = ^{ys[STAGES], zs[STAGES]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= '0;
            i2 <= '0;
            q2 <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                xs[s] <= '0;
                ys[s] <= '0;
                zs[s] <= '0;
            end
        end else begin
            ph <= acc + poff + pinc * KMUL;
            i2 <= i_in;
            q2 <= q_in;
            case (ph[19:18])
                2'b00: begin xs[0] <= xe;  ys[0] <= ye;  end
                2'b01: begin xs[0] <= -ye; ys[0] <= xe;  end
                2'b10: begin xs[0] <= -xe; ys[0] <= -ye; end
                default: begin xs[0] <= ye; ys[0] <= -xe; end
            endcase
            zs[0] <= {2'b00, ph[17:0]};
            for (int s = 0; s < STAGES; s++) begin
                if (!zs[s][19]) begin
                    xs[s+1] <= xs[s] - (ys[s] >>> s);
                    ys[s+1] <= ys[s] + (xs[s] >>> s);
                    zs[s+1] <= zs[s] - atan_lut(s);
                end else begin
                    xs[s+1] <= xs[s] + (ys[s] >>> s);
                    ys[s+1] <= ys[s] - (xs[s] >>> s);
                    zs[s+1] <= zs[s] + atan_lut(s);
                end
            end
        end
    end

    always_comb begin
        rnd = {xs[STAGES][17], xs[STAGES]} + 19'sd2;
        sh  = rnd >>> 2;
        if (sh > 19'sd32767)       sat = 16'sh7fff;
        else if (sh < -19'sd32768) sat = 16'sh8000;
        else                       sat = sh[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout <= '0;
        else     dout <= vld ? sat : 16'sd0;
    end
endmodule

module duc_quad #(
    parameter int STAGES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] pinc,
    input  logic [19:0] poff,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] dac_out_0,
    output logic [15:0] dac_out_1,
    output logic [15:0] dac_out_2,
    output logic [15:0] dac_out_3,
    output logic        m_valid,
    output logic        busy,
    output logic [15:0] underflow_cnt
);
    localparam int NUM_LANES = 4;
    localparam int LAT       = STAGES + 4;
    localparam int CW        = $clog2(LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [CW-1:0]                  drain_cnt;
    logic [19:0]                    pinc_l, poff_l, acc, acc_r;
    logic signed [13:0]             i_r, q_r;
    logic [LAT:1]                   vld_pipe;
    logic [NUM_LANES-1:0][15:0]     dac;
    logic                           run, unused_bits;

    assign run         = (state == RUN);
    assign s_ready     = run;
    assign busy        = (state != IDLE);
    assign m_valid     = vld_pipe[LAT];
    assign unused_bits = ^{s_data[31:30], s_data[15:14]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == CW'(LAT - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            pinc_l        <= '0;
            poff_l        <= '0;
            acc           <= '0;
            acc_r         <= '0;
            i_r           <= '0;
            q_r           <= '0;
            vld_pipe      <= '0;
            underflow_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            if (state == IDLE && en) begin
                pinc_l <= pinc;
                poff_l <= poff;
            end
            acc   <= run ? acc + {pinc_l[17:0], 2'b00} : 20'd0;
            acc_r <= acc;
            // Zero-order hold: the same sample feeds all lanes; a starved RUN cycle feeds zeros.
            i_r   <= (run && s_valid) ? s_data[13:0]  : 14'sd0;
            q_r   <= (run && s_valid) ? s_data[29:16] : 14'sd0;
            vld_pipe <= {vld_pipe[LAT-1:1], run};
            if (run && !s_valid && underflow_cnt != 16'hffff)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        duc_lane #(.STAGES(STAGES), .LANE(k)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .acc  (acc_r),
            .pinc (pinc_l),
            .poff (poff_l),
            .i_in (i_r),
            .q_in (q_r),
            .vld  (vld_pipe[LAT-1]),
            .dout (dac[k])
        );
    end

    assign dac_out_0 = dac[0];
    assign dac_out_1 = dac[1];
    assign dac_out_2 = dac[2];
    assign dac_out_3 = dac[3];
endmodule

// File: tb/tb_duc_quad.sv
// Directed bench for duc_quad: tones, quadrant/offset paths, underflow, drain/restart, async reset.
module tb_duc_quad;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, s_valid = 1'b0;
    logic [19:0] pinc = '0, poff = '0;
    logic [31:0] s_data = '0;
    logic        s_ready, m_valid, busy;
    logic [15:0] dac_out_0, dac_out_1, dac_out_2, dac_out_3, underflow_cnt;
    logic signed [15:0] dac [4];
    int n_cmp = 0, n_bad = 0;

    duc_quad #(.STAGES(16)) dut (
        .clk(clk), .rst(rst), .en(en), .pinc(pinc), .poff(poff),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dac_out_0(dac_out_0), .dac_out_1(dac_out_1),
        .dac_out_2(dac_out_2), .dac_out_3(dac_out_3),
        .m_valid(m_valid), .busy(busy), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    assign dac[0] = dac_out_0;
    assign dac[1] = dac_out_1;
    assign dac[2] = dac_out_2;
    assign dac[3] = dac_out_3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [15:0] obs, input int exp, input int tol);
        int d;
        d = int'(obs) - exp;
        n_cmp++;
        assert (d <= tol && d >= -tol) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic set_sample(input logic [13:0] i, input logic [13:0] q);
        s_data = {2'b00, q, 2'b00, i};
    endtask

    task automatic drain();
        en = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (!busy) break;
        end
        chk("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    // Runs ncyc+1 RUN cycles; if gs>=0, s_valid is low for cycles gs..gs+4.
    task automatic run_tone(input string tag, input logic [19:0] pi, input logic [19:0] po,
                            input logic [13:0] ii, input logic [13:0] qq,
                            input int e0, input int e1, input int e2, input int e3,
                            input int gs, input int ncyc);
        int exp_l [4];
        int mv_early;
        bit gap;
        exp_l = '{e0, e1, e2, e3};
        mv_early = 0;
        pinc = pi; poff = po; set_sample(ii, qq);
        s_valid = 1'b1; en = 1'b1;
        tick();
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd1);
        for (int c = 0; c <= ncyc; c++) begin
            if (c < 20) mv_early += int'(m_valid);
            else begin
                chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd1);
                gap = (gs >= 0 && c >= gs + 20 && c < gs + 25);
                for (int k = 0; k < 4; k++) begin
                    if (gap) chk({tag, "_gap_zero"}, {{16{dac[k][15]}}, dac[k]}, 32'd0);
                    else     chk_near({tag, "_lane"}, dac[k], exp_l[k], 2);
                end
            end
            s_valid = !(gs >= 0 && c >= gs && c < gs + 5);
            tick();
        end
        chk({tag, "_mv_early"}, mv_early, 0);
        drain();
    endtask

    initial begin
        int mv, bc;
        #2;
        chk("rst_dac0", {16'd0, dac_out_0}, 0);
        chk("rst_dac3", {16'd0, dac_out_3}, 0);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_s_ready", {31'd0, s_ready}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_uflow", {16'd0, underflow_cnt}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        run_tone("tone", 20'd0, 20'd0, 14'd4096, 14'd0, 6745, 6745, 6745, 6745, 30, 60);
        chk("uflow_cnt", {16'd0, underflow_cnt}, 32'd5);
        run_tone("quarter", 20'h40000, 20'd0, 14'd4096, 14'd0, 6745, 0, -6745, 0, -1, 30);
        run_tone("qoff", 20'd0, 20'h40000, 14'd0, 14'd4096, -6745, -6745, -6745, -6745, -1, 25);
        run_tone("qoff3", 20'd0, 20'hC0000, 14'd0, 14'd4096, 6745, 6745, 6745, 6745, -1, 25);
        chk("uflow_hold", {16'd0, underflow_cnt}, 32'd5);

        // Drain after 30 RUN cycles; a mid-run pinc change must not take effect.
        pinc = 20'd0; poff = 20'd0; set_sample(14'd4096, 14'd0);
        s_valid = 1'b1; en = 1'b1;
        tick();
        mv = 0; bc = 0;
        for (int c = 0; c <= 60; c++) begin
            mv += int'(m_valid);
            if (c >= 30) bc += int'(busy);
            if (c == 25) chk_near("pinc_ignored", dac[2], 6745, 2);
            if (c == 10) pinc = 20'h10000;
            if (c == 29) en = 1'b0;
            tick();
        end
        chk("drain_mv_total", mv, 30);
        chk("drain_busy_cycles", bc, 20);
        chk("drain_idle_busy", {31'd0, busy}, 0);
        chk("drain_idle_dac1", {16'd0, dac_out_1}, 0);
        chk("drain_idle_ready", {31'd0, s_ready}, 0);

        // Restart with pinc=2^16: first output has acc=0, next has acc=2^18.
        en = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) tick();
        chk_near("restart0_l0", dac[0], 6745, 3);
        chk_near("restart0_l1", dac[1], 6232, 3);
        chk_near("restart0_l2", dac[2], 4769, 3);
        chk_near("restart0_l3", dac[3], 2581, 3);
        tick();
        chk_near("restart1_l0", dac[0], 0, 3);
        chk_near("restart1_l1", dac[1], -2581, 3);
        chk_near("restart1_l2", dac[2], -4769, 3);
        chk_near("restart1_l3", dac[3], -6232, 3);
        chk("restart_m_valid", {31'd0, m_valid}, 1);

        // Async reset mid-RUN, between edges.
        s_valid = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_dac0", {16'd0, dac_out_0}, 0);
        chk("arst_dac1", {16'd0, dac_out_1}, 0);
        chk("arst_dac2", {16'd0, dac_out_2}, 0);
        chk("arst_m_valid", {31'd0, m_valid}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_s_ready", {31'd0, s_ready}, 0);
        chk("arst_uflow", {16'd0, underflow_cnt}, 0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
